chunk_pool4: RTL and testbench
==============================

// Module: chunk_pool4
// PURPOSE
//  4-slot pool of 128-bit cache chunks (4 x 32-bit words) between the CPU memory ports and backing memory.
//  Serves a data port (masked write / read) and a separate combinational instruction-fetch (command) port.
//  Exposes the next victim slot (save_*) so the controller can write it back before a refill.
//  Refills (new_data_save) always overwrite the victim; slots are replaced round-robin.
// PARAMETERS
//  CHUNK_PART    128  chunk width in bits (= 4*DATA_SIZE)
//  DATA_SIZE     32   word width
//  MASK_SIZE     4    byte-enable width (DATA_SIZE/8)
//  ADDRESS_SIZE  28   byte address width; tag = address[ADDRESS_SIZE-1:4], word = address[3:2]
// PORTS
//  clk                       in   1             clock, all state on rising edge
//  reset_n                   in   1             synchronous active-low reset
//  address                   in   ADDRESS_SIZE  data-port byte address
//  mask                      in   MASK_SIZE     byte enables for write (bit i -> byte i)
//  write_trigger             in   1             masked write strobe (one cycle)
//  write_value               in   DATA_SIZE     write data
//  read_trigger              in   1             data read strobe
//  read_value                out  DATA_SIZE     data read result
//  contains_address          out  1             data read hit
//  command_address           in   ADDRESS_SIZE  fetch address
//  read_command              out  DATA_SIZE     fetch word (combinational)
//  contains_command_address  out  1             fetch hit (combinational)
//  save_address              out  ADDRESS_SIZE  victim chunk address {tag,4'b0}
//  save_data                 out  CHUNK_PART    victim chunk data {w3,w2,w1,w0}
//  save_need_flag            out  1             victim valid and dirty
//  order_index               out  16            victim slot index, zero-extended (0..3)
//  new_data                  in   CHUNK_PART    refill data {w3,w2,w1,w0}
//  new_address               in   ADDRESS_SIZE  refill address (bits [3:0] ignored)
//  new_data_save             in   1             refill strobe
// BEHAVIOUR
//  - Per slot: valid, dirty, tag[ADDRESS_SIZE-5:0], 4 words. Word k = data[32k+31:32k].
//  - Reset (reset_n=0 at edge): all valid=0, dirty=0, victim pointer=0, read_value=0, contains_address=0.
//  - Hit: slot valid && tag==addr[ADDRESS_SIZE-1:4]. Several slots may hold one tag; lowest index wins.
//  - Refill: on new_data_save, victim slot <= {valid=1, dirty=0, tag=new_address[..:4], new_data};
//    pointer <= pointer+1 mod 4. No duplicate check; old contents dropped (controller writes back first).
//  - Write: on write_trigger with hit, byte i of word address[3:2] <= write_value byte i where mask[i];
//    slot dirty<=1. Miss: ignored, no state change. Visible on all ports the next cycle.
//  - Read: on read_trigger, register contains_address<=hit, read_value<=hit ? word : 0; hold otherwise.
//  - Command port: purely combinational from current state; miss -> read_command=0, contains=0.
//  - save_*/order_index combinational from slot[pointer]; save_need_flag = valid & dirty.
//  - Same-cycle write + refill: write evaluated on pre-edge state; if it targets the victim slot the refill wins.
//  - Same-cycle read + write: read returns pre-write data.
//  - Address bits [1:0] ignored; no alignment checks.
// CONFIGURATION
//  CHUNK_POOL_READ_BYPASS_EN defined: read_value/contains_address become combinational from address
//    (read_trigger ignored, no reset value). Undefined (default): registered, as above.
// TESTING
//  - Reset -> save_need_flag=0, contains_address=0, contains_command_address=0, order_index=0.
//  - Refill 0x0A5000F,{DEADBEEF,CAFEBABE,12345678,87654321}; fetch 0x0A50004 -> read_command=12345678, hit=1.
//  - Refill 0x0A5000F,0x0A50020,0x0A50040, then 0x0A50060 x5 ({12345678}x4) -> save_need_flag=0,
//    save_address=0x0A50060, save_data={12345678}x4.
//  - Then read 0x0A50060 -> contains_address=1, read_value=12345678; fetch 0x0A50068 -> 12345678, hit=1.
//  - Write 0x0A50064 mask 0101 value A1B2C3D4 -> save_need_flag=1, save_address=0x0A50060,
//    save_data={12345678,12345678,12B256D4,12345678}.
//  - Write/read to absent 0x0B00000 -> no state change, contains_address=0, read_value=0.

Source files
------------

// File: rtl/chunk_pool4.sv
// Four-slot pool of 128-bit cache chunks with a data port, a combinational fetch port and round-robin refill.
// Define CHUNK_POOL_READ_BYPASS_EN to make the data read result combinational instead of registered.
module chunk_pool4 #(
    parameter int CHUNK_PART   = 128,
    parameter int DATA_SIZE    = 32,
    parameter int MASK_SIZE    = 4,
    parameter int ADDRESS_SIZE = 28
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [MASK_SIZE-1:0]    mask,
    input  logic                    write_trigger,
    input  logic [DATA_SIZE-1:0]    write_value,
    input  logic                    read_trigger,
    output logic [DATA_SIZE-1:0]    read_value,
    output logic                    contains_address,
    input  logic [ADDRESS_SIZE-1:0] command_address,
    output logic [DATA_SIZE-1:0]    read_command,
    output logic                    contains_command_address,
    output logic [ADDRESS_SIZE-1:0] save_address,
    output logic [CHUNK_PART-1:0]   save_data,
    output logic                    save_need_flag,
    output logic [15:0]             order_index,
    input  logic [CHUNK_PART-1:0]   new_data,
    input  logic [ADDRESS_SIZE-1:0] new_address,
    input  logic                    new_data_save
);
    localparam int SLOTS = 4;
    localparam int TAG_W = ADDRESS_SIZE - 4;
    localparam int IDX_W = $clog2(CHUNK_PART);

    logic [SLOTS-1:0]      valid_q, valid_d;
    logic [SLOTS-1:0]      dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [SLOTS];
    logic [TAG_W-1:0]      tag_d  [SLOTS];
    logic [CHUNK_PART-1:0] data_q [SLOTS];
    logic [CHUNK_PART-1:0] data_d [SLOTS];
    logic [1:0]            ptr_q, ptr_d;

    logic                  data_hit, cmd_hit;
    logic [1:0]            data_idx, cmd_idx;
    logic [IDX_W-1:0]      data_lsb, cmd_lsb;
    logic [DATA_SIZE-1:0]  data_word, cmd_word;
    logic                  unused_bits;

    assign unused_bits = ^{address[1:0], command_address[1:0], new_address[3:0], read_trigger};

    assign data_lsb = IDX_W'(address[3:2]) << $clog2(DATA_SIZE);
    assign cmd_lsb  = IDX_W'(command_address[3:2]) << $clog2(DATA_SIZE);

    // Scan from the top so the lowest matching slot is the one that sticks.
    always_comb begin
        data_hit = 1'b0;
        data_idx = '0;
        cmd_hit  = 1'b0;
        cmd_idx  = '0;
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (valid_q[s] && tag_q[s] == address[ADDRESS_SIZE-1:4]) begin
                data_hit = 1'b1;
                data_idx = 2'(s);
            end
            if (valid_q[s] && tag_q[s] == command_address[ADDRESS_SIZE-1:4]) begin
                cmd_hit = 1'b1;
                cmd_idx = 2'(s);
            end
        end
    end

    assign data_word = data_hit ? data_q[data_idx][data_lsb +: DATA_SIZE] : '0;
    assign cmd_word  = cmd_hit  ? data_q[cmd_idx][cmd_lsb +: DATA_SIZE]   : '0;

    assign read_command             = cmd_word;
    assign contains_command_address = cmd_hit;
    assign save_address             = {tag_q[ptr_q], 4'b0000};
    assign save_data                = data_q[ptr_q];
    assign save_need_flag           = valid_q[ptr_q] & dirty_q[ptr_q];
    assign order_index              = 16'(ptr_q);

    // A refill is applied after the write so it overrides a write to the victim slot.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (write_trigger && data_hit) begin
            for (int b = 0; b < MASK_SIZE; b++) begin
                if (mask[b]) begin
                    data_d[data_idx][data_lsb + IDX_W'(8 * b) +: 8] = write_value[8*b +: 8];
                end
            end
            dirty_d[data_idx] = 1'b1;
        end
        if (new_data_save) begin
            valid_d[ptr_q] = 1'b1;
            dirty_d[ptr_q] = 1'b0;
            tag_d[ptr_q]   = new_address[ADDRESS_SIZE-1:4];
            data_d[ptr_q]  = new_data;
            ptr_d          = ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
            ptr_q   <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

`ifdef CHUNK_POOL_READ_BYPASS_EN
    assign read_value       = data_word;
    assign contains_address = data_hit;
`else
    logic [DATA_SIZE-1:0] read_value_q, read_value_d;
    logic                 contains_q, contains_d;

    always_comb begin
        read_value_d = read_value_q;
        contains_d   = contains_q;
        if (read_trigger) begin
            read_value_d = data_word;
            contains_d   = data_hit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            read_value_q <= '0;
            contains_q   <= 1'b0;
        end else begin
            read_value_q <= read_value_d;
            contains_q   <= contains_d;
        end
    end

    assign read_value       = read_value_q;
    assign contains_address = contains_q;
`endif
endmodule

// File: tb/tb_chunk_pool4.sv
// Randomized self-checking bench for chunk_pool4 against a word-array reference model, plus directed scenarios.
module tb_chunk_pool4;
    localparam int AW = 28;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [AW-1:0]  address = '0;
    logic [3:0]     mask = '0;
    logic           write_trigger = 1'b0;
    logic [31:0]    write_value = '0;
    logic           read_trigger = 1'b0;
    logic [31:0]    read_value;
    logic           contains_address;
    logic [AW-1:0]  command_address = '0;
    logic [31:0]    read_command;
    logic           contains_command_address;
    logic [AW-1:0]  save_address;
    logic [127:0]   save_data;
    logic           save_need_flag;
    logic [15:0]    order_index;
    logic [127:0]   new_data = '0;
    logic [AW-1:0]  new_address = '0;
    logic           new_data_save = 1'b0;

    chunk_pool4 dut (
        .clk(clk), .reset_n(reset_n), .address(address), .mask(mask),
        .write_trigger(write_trigger), .write_value(write_value),
        .read_trigger(read_trigger), .read_value(read_value),
        .contains_address(contains_address), .command_address(command_address),
        .read_command(read_command), .contains_command_address(contains_command_address),
        .save_address(save_address), .save_data(save_data),
        .save_need_flag(save_need_flag), .order_index(order_index),
        .new_data(new_data), .new_address(new_address), .new_data_save(new_data_save)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: each slot is a tag plus four separately stored words.
    bit          m_valid [4];
    bit          m_dirty [4];
    logic [23:0] m_tag   [4];
    logic [31:0] m_word  [4][4];
    int          m_ptr;
    logic [31:0] m_rd;
    bit          m_rd_hit;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int findSlot(input logic [AW-1:0] a);
        for (int s = 0; s < 4; s++)
            if (m_valid[s] && m_tag[s] == a[AW-1:4]) return s;
        return -1;
    endfunction

    function automatic logic [127:0] modelChunk(input int s);
        return {m_word[s][3], m_word[s][2], m_word[s][1], m_word[s][0]};
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 0;
            m_dirty[s] = 0;
            m_tag[s]   = '0;
            for (int k = 0; k < 4; k++) m_word[s][k] = '0;
        end
        m_ptr    = 0;
        m_rd     = '0;
        m_rd_hit = 0;
    endtask

    task automatic modelStep();
        int ws;
        int w;
        ws = findSlot(address);
        w  = int'(address[3:2]);
        if (read_trigger) begin
            m_rd_hit = (ws >= 0);
            m_rd     = (ws >= 0) ? m_word[ws][w] : 32'd0;
        end
        if (write_trigger && ws >= 0) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) m_word[ws][w][8*b +: 8] = write_value[8*b +: 8];
            m_dirty[ws] = 1;
        end
        if (new_data_save) begin
            m_valid[m_ptr] = 1;
            m_dirty[m_ptr] = 0;
            m_tag[m_ptr]   = new_address[AW-1:4];
            for (int k = 0; k < 4; k++) m_word[m_ptr][k] = new_data[32*k +: 32];
            m_ptr = (m_ptr + 1) % 4;
        end
    endtask

    // Entered at posedge+1; checks combinational outputs mid-cycle, registered outputs after the edge.
    task automatic runCycle();
        int cs;
        #3;
        cs = findSlot(command_address);
        checkOutput("contains_command", contains_command_address, cs >= 0);
        checkOutput("read_command", read_command, cs >= 0 ? m_word[cs][command_address[3:2]] : 32'd0);
        checkOutput("save_need_flag", save_need_flag, m_valid[m_ptr] && m_dirty[m_ptr]);
        checkOutput("order_index", order_index, 16'(m_ptr));
        if (m_valid[m_ptr]) begin
            checkOutput("save_address", save_address, {m_tag[m_ptr], 4'b0000});
            checkOutput("save_data", save_data, modelChunk(m_ptr));
        end
        @(posedge clk);
        if (!reset_n) modelReset();
        else modelStep();
        #1;
        checkOutput("contains_address", contains_address, m_rd_hit);
        checkOutput("read_value", read_value, m_rd);
    endtask

    task automatic applyStimulus(input logic wt, input logic rt, input logic ns,
                                 input logic [AW-1:0] a, input logic [3:0] m, input logic [31:0] wv,
                                 input logic [AW-1:0] ca, input logic [AW-1:0] na, input logic [127:0] nd);
        write_trigger   = wt;
        read_trigger    = rt;
        new_data_save   = ns;
        address         = a;
        mask            = m;
        write_value     = wv;
        command_address = ca;
        new_address     = na;
        new_data        = nd;
        runCycle();
        write_trigger   = 1'b0;
        read_trigger    = 1'b0;
        new_data_save   = 1'b0;
    endtask

    task automatic refill(input logic [AW-1:0] na, input logic [127:0] nd);
        applyStimulus(0, 0, 1, '0, '0, '0, '0, na, nd);
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_save_need", save_need_flag, 1'b0);
        checkOutput("rst_contains", contains_address, 1'b0);
        checkOutput("rst_contains_cmd", contains_command_address, 1'b0);
        checkOutput("rst_order_index", order_index, 16'd0);
        checkOutput("rst_read_value", read_value, 32'd0);
        reset_n = 1'b1;

        refill(28'h0A5000F, {32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h87654321});
        command_address = 28'h0A50004;
        #1;
        checkOutput("dir_fetch_hit", contains_command_address, 1'b1);
        checkOutput("dir_fetch_word", read_command, 32'h12345678);

        refill(28'h0A50020, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
        refill(28'h0A50040, {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888});
        repeat (5) refill(28'h0A50060, {4{32'h12345678}});
        checkOutput("dir_victim_clean", save_need_flag, 1'b0);
        checkOutput("dir_victim_addr", save_address, 28'h0A50060);
        checkOutput("dir_victim_data", save_data, {4{32'h12345678}});

        applyStimulus(0, 1, 0, 28'h0A50060, '0, '0, 28'h0A50068, '0, '0);
        checkOutput("dir_read_hit", contains_address, 1'b1);
        checkOutput("dir_read_value", read_value, 32'h12345678);
        checkOutput("dir_fetch2_hit", contains_command_address, 1'b1);
        checkOutput("dir_fetch2_word", read_command, 32'h12345678);

        applyStimulus(1, 0, 0, 28'h0A50064, 4'b0101, 32'hA1B2C3D4, 28'h0A50068, '0, '0);
        checkOutput("dir_dirty", save_need_flag, 1'b1);
        checkOutput("dir_dirty_addr", save_address, 28'h0A50060);
        checkOutput("dir_dirty_data", save_data,
                    {32'h12345678, 32'h12345678, 32'h12B256D4, 32'h12345678});

        applyStimulus(1, 1, 0, 28'h0B00000, 4'b1111, 32'hFFFFFFFF, 28'h0B00000, '0, '0);
        checkOutput("dir_miss_contains", contains_address, 1'b0);
        checkOutput("dir_miss_value", read_value, 32'd0);
        checkOutput("dir_miss_fetch", contains_command_address, 1'b0);
        checkOutput("dir_miss_keep", save_data,
                    {32'h12345678, 32'h12345678, 32'h12B256D4, 32'h12345678});

        for (int i = 0; i < 500; i++) begin
            logic [AW-1:0] a, ca, na;
            logic [127:0]  nd;
            a  = {24'h0A5000 + 24'($urandom_range(0, 5)), 4'($urandom)};
            ca = {24'h0A5000 + 24'($urandom_range(0, 6)), 4'($urandom)};
            na = {24'h0A5000 + 24'($urandom_range(0, 5)), 4'($urandom)};
            nd = {$urandom, $urandom, $urandom, $urandom};
            reset_n = ($urandom_range(0, 80) != 0);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), a, 4'($urandom), $urandom, ca, na, nd);
        end
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
